// File: rtl/mem_arbiter.sv
// mem_arbiter: one single-port unified memory shared by fetch (F) and memory stage (M); data wins conflicts; optional perf counters via ARB_PERF_CNT_EN.
// Latency: grant on the edge after a request is seen in IDLE; Ready is combinational with MemAck; one idle cycle between transactions.
// Backpressure: StallF/StallM held while a request is outstanding; watchdog (TIMEOUT>0) aborts unacknowledged requests with BusErr.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          IReqF,
    input  logic [AW-1:0] IAddrF,
    output logic [DW-1:0] IRdataF,
    output logic          IReadyF,
    input  logic          DReqM,
    input  logic          DWeM,
    input  logic [AW-1:0] DAddrM,
    input  logic [DW-1:0] DWdataM,
    output logic [DW-1:0] DRdataM,
    output logic          DReadyM,
    output logic          BusErr,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemAck,
    output logic          StallF,
    output logic          StallM,
    output logic [31:0]   IGrantCnt,
    output logic [31:0]   DGrantCnt,
    output logic [31:0]   ConflictCnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } stateT;

    // Wait counter only has to reach TIMEOUT-1; a zero TIMEOUT disables the abort path.
    localparam int CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TLIM    = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit WDOG_EN = (TIMEOUT > 0);

    stateT         state;
    logic [CW-1:0] waitCnt;
    logic          busy;
    logic          ackHit;
    logic          timeoutHit;
    logic          done;

    // Completion decode: a real ack always beats the watchdog in the same cycle,
    // and nothing completes while reset is held or outside a BUSY state.
    assign busy       = (state == IBUSY) || (state == DBUSY);
    assign ackHit     = busy && MemAck && !reset;
    assign timeoutHit = WDOG_EN && busy && !MemAck && !reset && (waitCnt == CW'(TLIM));
    assign done       = ackHit || timeoutHit;

    assign IReadyF = done && (state == IBUSY);
    assign DReadyM = done && (state == DBUSY);
    assign BusErr  = timeoutHit;

    // Read data is only forwarded on a genuine ack; aborted or idle cycles return zero.
    assign IRdataF = (ackHit && (state == IBUSY)) ? MemRdata : '0;
    assign DRdataM = (ackHit && (state == DBUSY)) ? MemRdata : '0;

    assign StallF = IReqF && !IReadyF;
    assign StallM = DReqM && !DReadyM;

    // Arbitration FSM: latch the granted request, hold it until ack or abort, then idle one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
            waitCnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (DReqM) begin
                        state    <= DBUSY;
                        MemReq   <= 1'b1;
                        MemWe    <= DWeM;
                        MemAddr  <= DAddrM;
                        MemWdata <= DWdataM;
                        waitCnt  <= '0;
                    end else if (IReqF) begin
                        state    <= IBUSY;
                        MemReq   <= 1'b1;
                        MemWe    <= 1'b0;
                        MemAddr  <= IAddrF;
                        MemWdata <= '0;
                        waitCnt  <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    if (done) begin
                        state  <= IDLE;
                        MemReq <= 1'b0;
                    end else begin
                        waitCnt <= waitCnt + CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    MemReq <= 1'b0;
                end
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Performance counters: grants per requester and IDLE cycles where both stages compete.
    always_ff @(posedge clk) begin
        if (reset) begin
            IGrantCnt   <= '0;
            DGrantCnt   <= '0;
            ConflictCnt <= '0;
        end else if (state == IDLE) begin
            if (DReqM) begin
                DGrantCnt <= DGrantCnt + 32'd1;
            end else if (IReqF) begin
                IGrantCnt <= IGrantCnt + 32'd1;
            end
            if (DReqM && IReqF) begin
                ConflictCnt <= ConflictCnt + 32'd1;
            end
        end
    end
`else
    assign IGrantCnt   = '0;
    assign DGrantCnt   = '0;
    assign ConflictCnt = '0;
`endif

endmodule
